fetch_stage: RTL

Instruction-fetch stage of the 16-bit pipelined CPU, directly upstream of the decode stage. It owns the PC and issues requests to instruction memory. It also holds the IF/ID pipeline register (`instruction`, `PC_plus_2`, `if_id_valid`) that decode consumes. It applies taken-branch redirects from decode, squashing wrong-path fetches, and stops fetching once a HLT (opcode 4'hF) has been accepted.

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// holds the IF/ID register, with branch redirect, a one-entry skid buffer and HLT stop.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchAddr,
    output logic [15:0] instruction,
    output logic [15:0] PC_plus_2,
    output logic        if_id_valid,
    output logic [15:0] pc,
    output logic        halted
);

    // state     | meaning
    // RUN       | fetching normally
    // HALT_PEND | HLT accepted from memory, waiting for decode to consume it
    // HALTED    | HLT consumed, fetch stopped until reset
    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

    state_t      state, state_nx;
    logic [15:0] pc_nx, req_pc, req_pc_nx;
    logic        outstanding, outstanding_nx;
    logic        kill, kill_nx;
    logic [15:0] skid_data, skid_data_nx, skid_pc2, skid_pc2_nx;
    logic        skid_valid, skid_valid_nx;
    logic [15:0] instr_nx, pc2_nx;
    logic        if_id_valid_nx;
    logic        consume, redirect, resp_ok, resp_hlt, issue;
    logic [15:0] resp_pc2;

    always_comb begin
        consume  = if_id_valid & ~stall & (state != HALTED);
        redirect = consume & BranchTaken;
        resp_ok  = imem_valid & outstanding & ~kill & ~redirect & (state != HALTED);
        resp_hlt = resp_ok & (imem_rdata[15:12] == 4'hF);
        resp_pc2 = req_pc + 16'd2;

        state_nx       = state;
        pc_nx          = pc;
        req_pc_nx      = req_pc;
        outstanding_nx = outstanding;
        kill_nx        = kill;
        skid_data_nx   = skid_data;
        skid_pc2_nx    = skid_pc2;
        skid_valid_nx  = skid_valid;
        instr_nx       = instruction;
        pc2_nx         = PC_plus_2;
        if_id_valid_nx = if_id_valid;
        issue          = 1'b0;

        if (state != HALTED) begin
            if (redirect) begin
                pc_nx          = BranchAddr;
                skid_valid_nx  = 1'b0;
                if_id_valid_nx = 1'b0;
                outstanding_nx = outstanding & ~imem_valid;
                kill_nx        = outstanding & ~imem_valid;
                state_nx       = RUN;
            end else begin
                if (kill && imem_valid) begin
                    kill_nx        = 1'b0;
                    outstanding_nx = 1'b0;
                end
                if (consume) begin
                    if (skid_valid) begin
                        instr_nx      = skid_data;
                        pc2_nx        = skid_pc2;
                        skid_valid_nx = 1'b0;
                        if (resp_ok) begin
                            skid_data_nx  = imem_rdata;
                            skid_pc2_nx   = resp_pc2;
                            skid_valid_nx = 1'b1;
                        end
                    end else if (resp_ok) begin
                        instr_nx = imem_rdata;
                        pc2_nx   = resp_pc2;
                    end else begin
                        if_id_valid_nx = 1'b0;
                    end
                    if (state == HALT_PEND && instruction[15:12] == 4'hF)
                        state_nx = HALTED;
                end else if (!if_id_valid) begin
                    if (resp_ok) begin
                        instr_nx       = imem_rdata;
                        pc2_nx         = resp_pc2;
                        if_id_valid_nx = 1'b1;
                    end
                end else if (resp_ok) begin
                    skid_data_nx  = imem_rdata;
                    skid_pc2_nx   = resp_pc2;
                    skid_valid_nx = 1'b1;
                end
                if (resp_ok)
                    outstanding_nx = 1'b0;
                if (resp_hlt && state == RUN)
                    state_nx = HALT_PEND;
                // Only issue when the returning word is guaranteed a slot (skid empty next cycle).
                issue = (state == RUN) & ~kill & ~resp_hlt & ~skid_valid_nx
                      & ~(outstanding & ~resp_ok);
                if (issue) begin
                    req_pc_nx      = pc;
                    pc_nx          = pc + 16'd2;
                    outstanding_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            req_pc      <= 16'h0000;
            outstanding <= 1'b0;
            kill        <= 1'b0;
            skid_data   <= 16'h0000;
            skid_pc2    <= 16'h0000;
            skid_valid  <= 1'b0;
            instruction <= 16'h0000;
            PC_plus_2   <= 16'h0000;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            req_pc      <= req_pc_nx;
            outstanding <= outstanding_nx;
            kill        <= kill_nx;
            skid_data   <= skid_data_nx;
            skid_pc2    <= skid_pc2_nx;
            skid_valid  <= skid_valid_nx;
            instruction <= instr_nx;
            PC_plus_2   <= pc2_nx;
            if_id_valid <= if_id_valid_nx;
        end
    end

    assign imem_req  = issue & rst_n;
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

endmodule
